// File: rtl/f1_delay_timer.sv
// Reaction-start delay timer: LFSR-randomised delay, counted down in 1 ms ticks, ending in a one-cycle time_out.
// Optional jump-start detection is enabled by defining F1_JUMP_START_EN.
module f1_delay_timer #(
    parameter int          MIN_DELAY_MS = 250,
    parameter int          RAND_BITS    = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        tick,
    input  logic        en_lfsr,
    input  logic        start_delay,
    input  logic        button,
    output logic        time_out,
    output logic        busy,
    output logic [13:0] delay_ms,
    output logic [13:0] remaining_ms,
    output logic        jump_start
);
    typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic        start_q;
    logic        armed;
    logic        rise;
    logic        expire;
    logic        abort;
    logic [13:0] load_val;

    if (RAND_BITS < 1 || RAND_BITS > 16) begin : g_bad_rand_bits
        $error("RAND_BITS must be in 1..16");
    end
    if (LFSR_SEED == 16'd0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end
    if (MIN_DELAY_MS + (1 << RAND_BITS) - 1 >= (1 << 14)) begin : g_bad_range
        $error("MIN_DELAY_MS + 2**RAND_BITS - 1 does not fit in 14 bits");
    end

    localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

    assign load_val = 14'(16'(MIN_DELAY_MS) + (lfsr & RAND_MASK));

    // armed blocks edge detection for the first cycle after reset, so a
    // start_delay held high through reset release is not seen as a rise.
    assign rise = start_delay & ~start_q & armed;

`ifdef F1_JUMP_START_EN
    assign abort = (state == COUNT) && button;
`else
    logic unused_button;
    assign unused_button = button;
    assign abort         = 1'b0;
`endif

    // A jump-start in the same cycle as the final tick takes priority.
    assign expire = (state == COUNT) && tick && (remaining_ms <= 14'd1) && !abort;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise) state_nxt = LOAD;
            LOAD:    state_nxt = COUNT;
            COUNT:   if (abort || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            start_q      <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
            time_out     <= 1'b0;
            delay_ms     <= '0;
            remaining_ms <= '0;
        end else begin
            start_q  <= start_delay;
            armed    <= 1'b1;
            busy     <= (state_nxt != IDLE);
            time_out <= expire;

            // The all-zero state is a lockup for this LFSR; recover to the seed.
            if (lfsr == 16'd0)
                lfsr <= LFSR_SEED;
            else if (en_lfsr)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};

            unique case (state)
                LOAD: begin
                    delay_ms     <= load_val;
                    remaining_ms <= load_val;
                end
                COUNT: begin
                    if (abort || expire) remaining_ms <= '0;
                    else if (tick)       remaining_ms <= remaining_ms - 14'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef F1_JUMP_START_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst)                        jump_start <= 1'b0;
        else if (state == IDLE && rise) jump_start <= 1'b0;
        else if (abort)                 jump_start <= 1'b1;
    end
`else
    assign jump_start = 1'b0;
`endif

endmodule

// File: tb/tb_f1_delay_timer.sv
// Bench for f1_delay_timer: vector table of LFSR-step/delay cases plus hand-written
// sequences for double start, coincident restart, mid-delay reset and jump start.
module tb_f1_delay_timer;
    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        en_lfsr = 1'b0;
    logic        start_delay = 1'b0;
    logic        button = 1'b0;
    logic        time_out;
    logic        busy;
    logic [13:0] delay_ms;
    logic [13:0] remaining_ms;
    logic        jump_start;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    f1_delay_timer dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .tick         (tick),
        .en_lfsr      (en_lfsr),
        .start_delay  (start_delay),
        .button       (button),
        .time_out     (time_out),
        .busy         (busy),
        .delay_ms     (delay_ms),
        .remaining_ms (remaining_ms),
        .jump_start   (jump_start)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard for time_out: every pulse must match a queued cycle number.
    always @(negedge sysclk) begin
        if (time_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL time_out_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                check("time_out_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; en_lfsr = 1'b0; start_delay = 1'b0; button = 1'b0;
        step();
        check("rst_busy",       busy,         0);
        check("rst_time_out",   time_out,     0);
        check("rst_delay_ms",   delay_ms,     0);
        check("rst_remaining",  remaining_ms, 0);
        check("rst_jump_start", jump_start,   0);
        rst = 1'b0;
        step();
    endtask

    task automatic advance_lfsr(input int steps);
        en_lfsr = 1'b1;
        repeat (steps) step();
        en_lfsr = 1'b0;
    endtask

    // Runs one full delay of n ticks spaced gap cycles apart. rise_tick issues
    // a second start_delay rise alongside that tick; btn_rem presses button
    // on a tick-free cycle when remaining_ms equals that value.
    task automatic run_delay(input int n, input int gap, input int rise_tick, input int btn_rem);
        int rem;
        start_delay = 1'b1; tick = 1'b0;
        step();
        check("busy_in_load", busy, 1);
        start_delay = 1'b0;
        step();
        check("delay_ms_load", delay_ms, n);
        check("remaining_load", remaining_ms, n);
        rem = n;
        for (int k = 1; k <= n; k++) begin
            for (int g = 1; g < gap; g++) begin
                tick = 1'b0;
                step();
                check("remaining_hold", remaining_ms, rem);
            end
            if (rem == btn_rem) begin
                button = 1'b1; tick = 1'b0;
                step();
                button = 1'b0;
`ifdef F1_JUMP_START_EN
                check("jump_start_set", jump_start, 1);
                check("jump_busy", busy, 0);
                check("jump_remaining", remaining_ms, 0);
                return;
`else
                check("jump_start_off", jump_start, 0);
                check("button_busy", busy, 1);
                check("button_remaining", remaining_ms, rem);
`endif
            end
            start_delay = (k == rise_tick);
            tick = 1'b1;
            if (k == n) exp_q.push_back(cyc + 1);
            step();
            tick = 1'b0; start_delay = 1'b0;
            rem--;
            check("remaining_tick", remaining_ms, rem);
            if (k == rise_tick) check("delay_ms_after_rise", delay_ms, n);
        end
        check("busy_after_expiry", busy, 0);
        check("jump_start_normal", jump_start, 0);
    endtask

    typedef struct {
        int steps;
        int gap;
        int rise_tick;
        int exp_delay;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{steps: 0, gap: 1, rise_tick: -1,  exp_delay: 3547};
        vecs[1] = '{steps: 1, gap: 2, rise_tick: -1,  exp_delay: 2749};
        vecs[2] = '{steps: 2, gap: 3, rise_tick: 100, exp_delay: 1152};
        vecs[3] = '{steps: 3, gap: 1, rise_tick: -1,  exp_delay: 2054};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            advance_lfsr(vecs[i].steps);
            run_delay(vecs[i].exp_delay, vecs[i].gap, vecs[i].rise_tick, -1);
            step();
            check("time_out_single", time_out, 0);
        end

        // Rise coincident with time_out restarts immediately.
        do_reset();
        advance_lfsr(2);
        run_delay(1152, 1, -1, -1);
        check("time_out_coincident", time_out, 1);
        start_delay = 1'b1;
        step();
        check("busy_after_coincident_rise", busy, 1);
        start_delay = 1'b0;
        step();
        check("delay_ms_restart", delay_ms, 1152);
        for (int k = 1; k <= 152; k++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        check("remaining_before_rst", remaining_ms, 1000);

        // Asynchronous reset mid-delay, with start_delay held through release.
        #2 rst = 1'b1;
        start_delay = 1'b1;
        #1;
        check("async_rst_busy",      busy,         0);
        check("async_rst_delay_ms",  delay_ms,     0);
        check("async_rst_remaining", remaining_ms, 0);
        check("async_rst_time_out",  time_out,     0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("held_start_no_delay", busy, 0);
        end
        start_delay = 1'b0;
        step();
        check("held_start_released", busy, 0);

        // Button at remaining_ms == 500.
        do_reset();
        run_delay(3547, 1, -1, 500);
`ifdef F1_JUMP_START_EN
        repeat (3) step();
        check("jump_start_sticky", jump_start, 1);
        start_delay = 1'b1;
        step();
        start_delay = 1'b0;
        check("jump_start_cleared", jump_start, 0);
        check("busy_after_jump_rise", busy, 1);
        do_reset();
`endif

        repeat (4) step();
        check("pending_time_outs", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
